// File: rtl/serv_sleep_ctrl.sv
// serv_sleep_ctrl: WFI sleep/wakeup controller sitting between the CSR/IRQ inputs and
//   the clock-gating / top-level wake logic of the SERV core.
// Latency: SLEEP is entered one cycle after a WFI entry strobe. Wake is one cycle after
//   the wake condition, or WAKE_DELAY cycles after entering WAKE. All outputs are registered.
// Backpressure: none. entry is ignored while asleep or waking. Wake sources are sticky while asleep.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_irq, i_irq_en   NUM_IRQ interrupt levels and per-source wake enables
//   i_wfi, i_cnt0,    WFI decode qualified by serial counter cycle 0 and the init phase
//   i_init
//   o_sleep_req       level, core clock may be gated while high (SLEEP only)
//   o_wakeup_req      single-cycle wake pulse
//   o_sleeping        high in SLEEP or WAKE
//   o_pending         sticky wake sources captured while asleep
// Optional build macro SERV_SLEEP_DBG_EN adds i_dbg_req (unmaskable wake source) and
//   o_dbg_wake (flags that the last wake was caused by a debug request).
module serv_sleep_ctrl #(
  parameter int NUM_IRQ        = 2,
  parameter int WAKE_DELAY     = 0,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_irq_en,
  input  logic               i_wfi,
  input  logic               i_cnt0,
  input  logic               i_init,
`ifdef SERV_SLEEP_DBG_EN
  input  logic               i_dbg_req,
  output logic               o_dbg_wake,
`endif
  output logic               o_sleep_req,
  output logic               o_wakeup_req,
  output logic               o_sleeping,
  output logic [NUM_IRQ-1:0] o_pending
);

  localparam int CW = (WAKE_DELAY > 0) ? $clog2(WAKE_DELAY + 1) : 1;
  localparam logic [CW-1:0] DELAY_LOAD = (WAKE_DELAY > 0) ? CW'(WAKE_DELAY - 1) : '0;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SLEEP = 2'd1;
  localparam logic [1:0] WAKE  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          entry;
  logic          dbg_cond;
  logic          wake_cond;

  assign entry = i_wfi & i_cnt0 & i_init;

`ifdef SERV_SLEEP_DBG_EN
  assign dbg_cond = i_dbg_req;
`else
  assign dbg_cond = 1'b0;
`endif

  // Pending bits take part, so a source that pulsed and dropped while asleep
  // still wakes the core once its enable is set.
  assign wake_cond = (|((i_irq | o_pending) & i_irq_en)) | dbg_cond;

  always_ff @(posedge i_clk) begin
    o_wakeup_req <= 1'b0;
    case (state)
      RUN: begin
        if (entry) begin
`ifdef SERV_SLEEP_DBG_EN
          o_dbg_wake <= 1'b0;
`endif
          if (wake_cond) begin
            // WFI acts as a NOP. The inversion keeps the pulse from ever lasting
            // two cycles when entry lands on the cycle a wake pulse is already out.
            o_wakeup_req <= ~o_wakeup_req;
          end else begin
            state       <= SLEEP;
            o_sleep_req <= 1'b1;
            o_sleeping  <= 1'b1;
          end
        end
      end
      SLEEP: begin
        o_pending <= o_pending | i_irq;
        if (wake_cond) begin
          o_sleep_req <= 1'b0;
`ifdef SERV_SLEEP_DBG_EN
          if (i_dbg_req) o_dbg_wake <= 1'b1;
`endif
          if (WAKE_DELAY == 0) begin
            state        <= RUN;
            o_wakeup_req <= 1'b1;
            o_sleeping   <= 1'b0;
            o_pending    <= '0;
          end else begin
            state <= WAKE;
            cnt   <= DELAY_LOAD;
          end
        end
      end
      WAKE: begin
        // Once started, the wake runs to completion even if the source drops.
        if (cnt == '0) begin
          state        <= RUN;
          o_wakeup_req <= 1'b1;
          o_sleeping   <= 1'b0;
          o_pending    <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      default: state <= RUN;
    endcase

    if (i_rst) begin
      state <= RUN;
      if (RESET_STRATEGY != "NONE") begin
        o_sleep_req  <= 1'b0;
        o_wakeup_req <= 1'b0;
        o_sleeping   <= 1'b0;
        o_pending    <= '0;
        cnt          <= '0;
`ifdef SERV_SLEEP_DBG_EN
        o_dbg_wake   <= 1'b0;
`endif
      end
    end
  end

endmodule
